mb_writeback_luma16x16: RTL and testbench

MB_WRITEBACK_LUMA16X16 -- requirements
Module: mb_writeback_luma16x16

---
 rtl/mb_writeback_luma16x16.sv | 218 +++++++++++++++++++++
 tb/tb_mb_writeback_luma16x16.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mb_writeback_luma16x16.sv
// ---------------------------------------------------------------------------
// mb_writeback_luma16x16
//
// Writes one reconstructed 16x16 luma macroblock into an on-chip frame store,
// one 16-pixel row per accepted beat, and serves single-pixel neighbour reads
// from the same store at any time.
//
// Parameters
//   LENGTH  frame height in pixels (multiple of 16)
//   WIDTH   frame width in pixels (multiple of 16)
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-low reset
//   start        request to write one macroblock (sampled in IDLE only)
//   mbnumber     raster macroblock index, sampled with start
//   row_valid    row_pixels carries one valid macroblock row
//   row_pixels   16 x 8-bit pixels, element 0 = leftmost
//   row_ready    block accepts a row this cycle (WRITE state)
//   busy         writeback in progress (WRITE or DONE)
//   done         one-cycle pulse after the 16th row is written
//   err          one-cycle pulse when a start is rejected
//   rd_en        neighbour-pixel read request
//   rd_addr      linear pixel address row*WIDTH + col
//   rd_data      read data, valid the cycle after rd_en, held otherwise
//
// Build option
//   MBWB_OOR_CHECK_EN  when defined, a start with an out-of-range mbnumber is
//                      rejected with an err pulse; when undefined, err is tied
//                      low and mbnumber is wrapped modulo the macroblock count.
//
// Storage organisation
//   A macroblock row is 16 horizontally adjacent pixels starting at a column
//   that is a multiple of 16, so pixel j of a beat always lands at an address
//   whose low nibble is j. The store is therefore split into 16 column banks
//   (bank = addr[3:0], word = addr>>4), each with one write and one read port,
//   which lets a whole row be written in a single cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module mb_writeback_luma16x16 #(
    parameter int LENGTH = 256,
    parameter int WIDTH  = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [12:0]      mbnumber,
    input  logic             row_valid,
    input  logic [15:0][7:0] row_pixels,
    output logic             row_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             rd_en,
    input  logic [15:0]      rd_addr,
    output logic [7:0]       rd_data
);

    // -----------------------------------------------------------------------
    // Geometry
    // -----------------------------------------------------------------------
    localparam logic [31:0] MBW   = 32'(WIDTH / 16);
    localparam logic [31:0] MBS   = 32'((LENGTH / 16) * (WIDTH / 16));
    localparam logic [31:0] NPIX  = 32'(LENGTH * WIDTH);
    localparam int          DEPTH = (LENGTH * WIDTH) / 16;
    localparam int          IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]      state;
    logic [3:0]      row_cnt;
    logic [15:0]     orow;      // macroblock origin row, pixels
    logic [15:0]     ocol;      // macroblock origin column, pixels
    logic            accept;
    logic [IDXW-1:0] wr_idx;
    logic [IDXW-1:0] rd_idx;

    // -----------------------------------------------------------------------
    // Macroblock index -> origin
    // -----------------------------------------------------------------------
    logic [12:0] mb_eff;
    logic [15:0] mb_row;
    logic [15:0] mb_col;
    logic        start_ok;

`ifdef MBWB_OOR_CHECK_EN
    logic mb_oor;
    logic err_q;

    assign mb_oor   = 32'(mbnumber) >= MBS;
    assign mb_eff   = mbnumber;
    assign start_ok = start && !mb_oor;

    // Reject only starts that would otherwise have been taken, i.e. in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state == S_IDLE) && start && mb_oor;
        end
    end
    assign err = err_q;
`else
    // Out-of-range indices wrap onto the frame instead of being rejected.
    assign mb_eff   = 13'(32'(mbnumber) % MBS);
    assign start_ok = start;
    assign err      = 1'b0;
`endif

    assign mb_row = 16'(32'(mb_eff) / MBW);
    assign mb_col = 16'(32'(mb_eff) % MBW);

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            row_cnt <= 4'd0;
            orow    <= 16'd0;
            ocol    <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        orow    <= mb_row << 4;
                        ocol    <= mb_col << 4;
                        row_cnt <= 4'd0;
                        state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // row_valid low is a plain stall: nothing moves.
                    if (row_valid) begin
                        row_cnt <= row_cnt + 4'd1;
                        if (row_cnt == 4'd15) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign row_ready = (state == S_WRITE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign accept    = row_ready && row_valid;

    // Word address shared by all 16 banks for the current beat:
    // ((orow + k) * WIDTH + ocol) >> 4, evaluated in 16 bits.
    assign wr_idx = IDXW'(((orow + 16'(row_cnt)) * 16'(WIDTH) + ocol) >> 4);
    assign rd_idx = IDXW'(rd_addr >> 4);

    // -----------------------------------------------------------------------
    // Column banks. Storage has no reset so that reset never disturbs pixels
    // already written. The read register samples the array before the same
    // edge's write lands, which gives read-before-write on a collision.
    // -----------------------------------------------------------------------
    logic [15:0][7:0] bank_q;

    for (genvar b = 0; b < 16; b++) begin : g_bank
        logic [7:0] ram [DEPTH];
        logic [7:0] q;

        always_ff @(posedge clk) begin
            if (accept) begin
                ram[wr_idx] <= row_pixels[b];
            end
        end

        always_ff @(posedge clk) begin
            if (rd_en) begin
                q <= ram[rd_idx];
            end
        end

        assign bank_q[b] = q;
    end

    // -----------------------------------------------------------------------
    // Read output. Bank select and the out-of-range flag are registered with
    // the bank data so that rd_data holds as a whole while rd_en is low.
    // rd_have keeps rd_data at zero from reset until the first read.
    // -----------------------------------------------------------------------
    logic [3:0] rd_sel;
    logic       rd_oor;
    logic       rd_have;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_sel  <= 4'd0;
            rd_oor  <= 1'b0;
            rd_have <= 1'b0;
        end else if (rd_en) begin
            rd_sel  <= rd_addr[3:0];
            rd_oor  <= {16'd0, rd_addr} >= NPIX;
            rd_have <= 1'b1;
        end
    end

    always_comb begin
        rd_data = 8'd0;
        if (rd_have) begin
            rd_data = rd_oor ? 8'd128 : bank_q[rd_sel];
        end
    end

endmodule

// File: tb/tb_mb_writeback_luma16x16.sv
`timescale 1ns/1ps

module tb_mb_writeback_luma16x16;

    localparam int L    = 256;
    localparam int W    = 256;
    localparam int NPIX = L * W;
    localparam int MBW  = W / 16;
    localparam int NMB  = (L / 16) * (W / 16);

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [12:0]      mbnumber;
    logic             row_valid;
    logic [15:0][7:0] row_pixels;
    logic             row_ready, busy, done, err;
    logic             rd_en;
    logic [15:0]      rd_addr;
    logic [7:0]       rd_data;

    // Second, smaller frame so that out-of-range read addresses are reachable
    // with a 16-bit rd_addr.
    logic             s_row_ready, s_busy, s_done, s_err;
    logic             s_rd_en;
    logic [15:0]      s_rd_addr;
    logic [7:0]       s_rd_data;
    logic [15:0][7:0] s_pix;

    always #5 clk = ~clk;

    mb_writeback_luma16x16 #(.LENGTH(L), .WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .mbnumber(mbnumber),
        .row_valid(row_valid), .row_pixels(row_pixels), .row_ready(row_ready),
        .busy(busy), .done(done), .err(err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    mb_writeback_luma16x16 #(.LENGTH(64), .WIDTH(256)) dut_small (
        .clk(clk), .reset(reset), .start(1'b0), .mbnumber(13'd0),
        .row_valid(1'b0), .row_pixels(s_pix), .row_ready(s_row_ready),
        .busy(s_busy), .done(s_done), .err(s_err),
        .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data)
    );

    // Reference frame store, filled from the writes the bench issues.
    logic [7:0] ref_mem [NPIX];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Linear address of pixel j in row k of macroblock mbn (index wrapped).
    function automatic int paddr(input int mbn, input int k, input int j);
        int m;
        m = mbn % NMB;
        return ((m / MBW) * 16 + k) * W + (m % MBW) * 16 + j;
    endfunction

    task automatic rd_chk(input int a, input string tag);
        rd_en   = 1'b1;
        rd_addr = 16'(a);
        tick();
        rd_en = 1'b0;
        chk(tag, rd_data, ref_mem[a]);
    endtask

    task automatic rd_const(input int a, input logic [7:0] exp, input string tag);
        rd_en   = 1'b1;
        rd_addr = 16'(a);
        tick();
        rd_en = 1'b0;
        chk(tag, rd_data, exp);
    endtask

    // Writes one macroblock. stall_pct: random row_valid drop rate. A forced
    // gap of gap_len cycles follows beat gap_after. ign_start drives start
    // (mbnumber 5) during stalls. rbw reads beat-0 pixel 0 in the beat-0
    // write cycle. abort_after >= 0 pulls reset after that beat. pattern
    // uses pixel = row*16+col instead of random data.
    task automatic write_mb(input int mbn, input int stall_pct, input int gap_after,
                            input int gap_len, input bit ign_start, input bit rbw,
                            input int abort_after, input bit pattern);
        int k, gaps, cyc, ra;
        logic v;
        logic [7:0] px [16];
        logic [7:0] old;
        k = 0; gaps = 0; cyc = 0; ra = 0; old = 8'd0;
        start    = 1'b1;
        mbnumber = 13'(mbn);
        tick();
        start = 1'b0;
        chk("row_ready_after_start", row_ready, 1);
        chk("busy_after_start", busy, 1);
        chk("err_on_valid_start", err, 0);
        while (k < 16 && cyc < 400) begin
            v = 1'b1;
            if (k == gap_after + 1 && gaps < gap_len) begin
                v = 1'b0;
                gaps++;
            end else if (int'($urandom_range(99)) < stall_pct) begin
                v = 1'b0;
            end
            row_valid = v;
            for (int j = 0; j < 16; j++) begin
                px[j]         = pattern ? 8'(k * 16 + j) : 8'($urandom);
                row_pixels[j] = px[j];
            end
            if (ign_start && !v) begin
                start    = 1'b1;
                mbnumber = 13'd5;
            end
            if (rbw && k == 0 && v) begin
                ra      = paddr(mbn, 0, 0);
                rd_en   = 1'b1;
                rd_addr = 16'(ra);
                old     = ref_mem[ra];
            end
            tick();
            cyc++;
            start     = 1'b0;
            row_valid = 1'b0;
            rd_en     = 1'b0;
            if (rbw && k == 0 && v) chk("rbw_old_value", rd_data, old);
            if (v) begin
                for (int j = 0; j < 16; j++) ref_mem[paddr(mbn, k, j)] = px[j];
                k++;
            end
            chk("err_low_in_write", err, 0);
            if (abort_after >= 0 && k == abort_after + 1) begin
                #2 reset = 1'b0;
                #1;
                chk("abort_busy", busy, 0);
                chk("abort_row_ready", row_ready, 0);
                chk("abort_done", done, 0);
                chk("abort_rd_data", rd_data, 0);
                tick();
                reset = 1'b1;
                tick();
                chk("abort_idle", busy, 0);
                return;
            end
            chk("done_timing", done, (k == 16) ? 1 : 0);
            chk("busy_during", busy, 1);
            chk("row_ready_during", row_ready, (k < 16) ? 1 : 0);
        end
        if (k < 16) chk("write_timeout_beats", k, 16);
        tick();
        chk("done_single_pulse", done, 0);
        chk("busy_cleared", busy, 0);
        if (rbw) rd_chk(ra, "rbw_new_value");
    endtask

    initial begin
        logic [7:0] held;
        reset = 1'b0; start = 1'b0; mbnumber = 13'd0; row_valid = 1'b0;
        row_pixels = '0; rd_en = 1'b0; rd_addr = 16'd0;
        s_rd_en = 1'b0; s_rd_addr = 16'd0; s_pix = '0;
        repeat (2) tick();
        chk("reset_busy", busy, 0);
        chk("reset_row_ready", row_ready, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_rd_data", rd_data, 0);
        chk("reset_small_rd_data", s_rd_data, 0);
        reset = 1'b1;
        tick();
        chk("idle_row_ready", row_ready, 0);

        // Fill the whole frame with random macroblocks and random stalls.
        for (int m = 0; m < NMB; m++) write_mb(m, 20, -10, 0, 1'b0, 1'b0, -1, 1'b0);
        for (int i = 0; i < 300; i++) rd_chk(int'($urandom_range(NPIX - 1)), "fill_read");
        held = ref_mem[NPIX - 1];
        rd_chk(NPIX - 1, "last_addr_read");
        tick();
        chk("rd_data_hold", rd_data, held);

        // MB 0, ramp pattern, back-to-back rows.
        write_mb(0, 0, -10, 0, 1'b0, 1'b0, -1, 1'b1);
        rd_const(0, 8'h00, "mb0_addr0");
        rd_const(15, 8'h0F, "mb0_addr15");
        rd_const(3840, 8'hF0, "mb0_addr3840");

        // MB 17 with a 3-cycle gap after beat 5 and an ignored start(5).
        write_mb(17, 0, 5, 3, 1'b1, 1'b0, -1, 1'b0);
        rd_chk(4112, "mb17_origin");
        for (int k = 0; k < 16; k++)
            for (int j = 0; j < 16; j++) rd_chk(paddr(17, k, j), "mb17_pixel");
        for (int k = 0; k < 16; k++) rd_chk(paddr(5, k, k), "mb5_untouched");

        // Read-before-write collision on MB 1.
        write_mb(1, 0, -10, 0, 1'b0, 1'b1, -1, 1'b0);

        // Out-of-range reads on the small frame.
        s_rd_en = 1'b1; s_rd_addr = 16'd16384;
        tick();
        chk("oor_read_16384", s_rd_data, 8'h80);
        s_rd_addr = 16'hFFFF;
        tick();
        s_rd_en = 1'b0;
        chk("oor_read_ffff", s_rd_data, 8'h80);

        // Reset after beat 7 of MB 34: rows 0..7 new, rows 8..15 unchanged.
        write_mb(34, 10, -10, 0, 1'b0, 1'b0, 7, 1'b0);
        for (int k = 0; k < 16; k++)
            for (int j = 0; j < 16; j += 5) rd_chk(paddr(34, k, j), "mb34_after_abort");

        // mbnumber beyond the last macroblock.
`ifdef MBWB_OOR_CHECK_EN
        start = 1'b1; mbnumber = 13'd256;
        tick();
        start = 1'b0;
        chk("oor_start_err", err, 1);
        chk("oor_start_busy", busy, 0);
        chk("oor_start_row_ready", row_ready, 0);
        tick();
        chk("oor_err_single", err, 0);
        chk("oor_still_idle", busy, 0);
        for (int j = 0; j < 16; j++) rd_chk(paddr(0, j, j), "mb0_not_written");
`else
        write_mb(256, 10, -10, 0, 1'b0, 1'b0, -1, 1'b0);
        for (int j = 0; j < 16; j++) rd_chk(paddr(0, j, j), "mb256_wraps_to_mb0");
`endif

        // Random macroblocks and random reads.
        for (int i = 0; i < 20; i++)
            write_mb(int'($urandom_range(NMB - 1)), 30, -10, 0, 1'b0, 1'b0, -1, 1'b0);
        for (int i = 0; i < 300; i++) rd_chk(int'($urandom_range(NPIX - 1)), "final_read");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
